enemy_fleet: RTL

- Owns the invader grid that feeds the top-level pixel painter: alive bitmap, fleet origin, march direction.
- Each frame: serially scans the player bullet box against every alive enemy, kills at most one, then steps the fleet.
- Per-pixel: tells the painter whether the current (x,y) lies on a live enemy.
- Produces the hit pulse wired to the player's hit_enemy_i, plus landed/cleared game-state flags.

---
 rtl/enemy_fleet.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/enemy_fleet.sv
// Invader grid: alive bitmap, marching origin, serial bullet scan and
// per-pixel enemy hit-test for the painter.
module enemy_fleet #(
    parameter int ROWS_P            = 4,
    parameter int COLS_P            = 8,
    parameter int CELL_W_P          = 32,
    parameter int CELL_H_P          = 32,
    parameter int SHIP_W_P          = 24,
    parameter int SHIP_H_P          = 16,
    parameter int LEFT_START_P      = 64,
    parameter int TOP_START_P       = 48,
    parameter int STEP_PX_P         = 4,
    parameter int DROP_PX_P         = 16,
    parameter int FRAMES_PER_STEP_P = 4,
    parameter int LAND_Y_P          = 429
) (
    input  logic       clk_i,
    input  logic       reset_n_async_unsafe_i,
    input  logic       frame_i,
    input  logic       start_i,
    input  logic       bullet_valid_i,
    input  logic [9:0] bullet_left_i,
    input  logic [9:0] bullet_right_i,
    input  logic [9:0] bullet_top_i,
    input  logic [9:0] bullet_bot_i,
    input  logic [9:0] x_i,
    input  logic [9:0] y_i,
    output logic       enemy_area_o,
    output logic       hit_o,
    output logic [5:0] alive_count_o,
    output logic       landed_o,
    output logic       cleared_o,
    output logic [2:0] state_o
);
    localparam int N       = ROWS_P * COLS_P;
    localparam int IDX_W   = $clog2(N);
    localparam int COL_W   = (COLS_P > 1) ? $clog2(COLS_P) : 1;
    localparam int ROW_W   = (ROWS_P > 1) ? $clog2(ROWS_P) : 1;
    localparam int CW_SH   = $clog2(CELL_W_P);
    localparam int CH_SH   = $clog2(CELL_H_P);
    localparam int DCW     = 11 - CW_SH;
    localparam int DRW     = 11 - CH_SH;
    localparam int FC_W    = $clog2(FRAMES_PER_STEP_P + 1);
    localparam int GRID_W  = COLS_P * CELL_W_P;
    localparam int BOT_OFF = (ROWS_P - 1) * CELL_H_P + SHIP_H_P;

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_SCAN, S_MOVE, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [N-1:0]       bitmap_q, bitmap_d;
    logic [9:0]         org_x_q, org_x_d, org_y_q, org_y_d;
    logic               dir_left_q, dir_left_d;
    logic [FC_W-1:0]    fc_q, fc_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [5:0]         count_q, count_d;
    logic               hit_q, hit_d, landed_q, landed_d, cleared_q, cleared_d;
    logic               area_q, area_d;

    logic [10:0] ex, ey;
    logic        overlap, kill, last;
    logic        step, mdir, land_now;
    logic [9:0]  mx, my;

    always_comb begin : scan_test
        ex = 11'(org_x_q) + (11'(col_q) << CW_SH);
        ey = 11'(org_y_q) + (11'(row_q) << CH_SH);
        overlap = bullet_valid_i
                  && (11'(bullet_left_i)  < ex + 11'(SHIP_W_P - 1))
                  && (11'(bullet_right_i) > ex)
                  && (11'(bullet_top_i)   < ey + 11'(SHIP_H_P - 1))
                  && (11'(bullet_bot_i)   > ey);
        kill = (state_q == S_SCAN) && overlap && bitmap_q[idx_q];
        last = (idx_q == IDX_W'(N - 1));
    end

    // Edge test covers the whole grid, so dead outer columns still bounce.
    always_comb begin : march
        step = (fc_q == FC_W'(FRAMES_PER_STEP_P - 1));
        mx   = org_x_q;
        my   = org_y_q;
        mdir = dir_left_q;
        if (step) begin
            if (!dir_left_q) begin
                if (12'(org_x_q) + 12'(GRID_W + STEP_PX_P) > 12'd640) begin
                    my   = org_y_q + 10'(DROP_PX_P);
                    mdir = 1'b1;
                end else begin
                    mx = org_x_q + 10'(STEP_PX_P);
                end
            end else if (org_x_q < 10'(STEP_PX_P)) begin
                my   = org_y_q + 10'(DROP_PX_P);
                mdir = 1'b0;
            end else begin
                mx = org_x_q - 10'(STEP_PX_P);
            end
        end
        land_now = (12'(my) + 12'(BOT_OFF)) > 12'(LAND_Y_P);
    end

    always_comb begin : next_state
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start_i) state_d = S_WAIT;
            S_WAIT: if (frame_i) state_d = S_SCAN;
            S_SCAN: if (kill || last) state_d = S_MOVE;
            S_MOVE: state_d = (count_q == 6'd0 || land_now) ? S_DONE : S_WAIT;
            S_DONE: if (start_i) state_d = S_WAIT;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin : datapath
        bitmap_d   = bitmap_q;
        org_x_d    = org_x_q;
        org_y_d    = org_y_q;
        dir_left_d = dir_left_q;
        fc_d       = fc_q;
        idx_d      = idx_q;
        col_d      = col_q;
        row_d      = row_q;
        count_d    = count_q;
        hit_d      = 1'b0;
        landed_d   = landed_q;
        cleared_d  = cleared_q;
        case (state_q)
            S_WAIT: if (frame_i) begin
                idx_d = '0;
                col_d = '0;
                row_d = '0;
            end
            S_SCAN: if (kill) begin
                bitmap_d[idx_q] = 1'b0;
                count_d         = count_q - 6'd1;
                hit_d           = 1'b1;
            end else if (!last) begin
                idx_d = idx_q + 1'b1;
                if (col_q == COL_W'(COLS_P - 1)) begin
                    col_d = '0;
                    row_d = row_q + 1'b1;
                end else begin
                    col_d = col_q + 1'b1;
                end
            end
            S_MOVE: begin
                org_x_d    = mx;
                org_y_d    = my;
                dir_left_d = mdir;
                fc_d       = step ? '0 : fc_q + 1'b1;
                if (count_q == 6'd0) cleared_d = 1'b1;
                else if (land_now)   landed_d  = 1'b1;
            end
            S_DONE: if (start_i) begin
                bitmap_d   = '1;
                org_x_d    = 10'(LEFT_START_P);
                org_y_d    = 10'(TOP_START_P);
                dir_left_d = 1'b0;
                fc_d       = '0;
                count_d    = 6'(N);
                landed_d   = 1'b0;
                cleared_d  = 1'b0;
            end
            default: ;
        endcase
    end

    logic [10:0]      rel_x, rel_y;
    logic [DCW-1:0]   d_col;
    logic [DRW-1:0]   d_row;
    logic [IDX_W-1:0] draw_idx;
    logic             in_x, in_y;

    // Pixels left of or above the origin never paint.
    always_comb begin : draw
        rel_x    = 11'(x_i) - 11'(org_x_q);
        rel_y    = 11'(y_i) - 11'(org_y_q);
        d_col    = rel_x[10:CW_SH];
        d_row    = rel_y[10:CH_SH];
        in_x     = (x_i >= org_x_q) && (d_col < DCW'(COLS_P))
                   && (rel_x[CW_SH-1:0] < CW_SH'(SHIP_W_P));
        in_y     = (y_i >= org_y_q) && (d_row < DRW'(ROWS_P))
                   && (rel_y[CH_SH-1:0] < CH_SH'(SHIP_H_P));
        draw_idx = IDX_W'(d_row[ROW_W-1:0]) * IDX_W'(COLS_P) + IDX_W'(d_col[COL_W-1:0]);
        area_d   = in_x && in_y && bitmap_q[draw_idx];
    end

    always_ff @(posedge clk_i or negedge reset_n_async_unsafe_i) begin
        if (!reset_n_async_unsafe_i) begin
            state_q    <= S_IDLE;
            bitmap_q   <= '1;
            org_x_q    <= 10'(LEFT_START_P);
            org_y_q    <= 10'(TOP_START_P);
            dir_left_q <= 1'b0;
            fc_q       <= '0;
            idx_q      <= '0;
            col_q      <= '0;
            row_q      <= '0;
            count_q    <= 6'(N);
            hit_q      <= 1'b0;
            landed_q   <= 1'b0;
            cleared_q  <= 1'b0;
            area_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bitmap_q   <= bitmap_d;
            org_x_q    <= org_x_d;
            org_y_q    <= org_y_d;
            dir_left_q <= dir_left_d;
            fc_q       <= fc_d;
            idx_q      <= idx_d;
            col_q      <= col_d;
            row_q      <= row_d;
            count_q    <= count_d;
            hit_q      <= hit_d;
            landed_q   <= landed_d;
            cleared_q  <= cleared_d;
            area_q     <= area_d;
        end
    end

    always_comb begin : outputs
        enemy_area_o  = area_q;
        hit_o         = hit_q;
        alive_count_o = count_q;
        landed_o      = landed_q;
        cleared_o     = cleared_q;
        state_o       = state_q;
    end
endmodule
